// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard.
// Combinational reads with optional same-cycle write bypass; async active-high reset.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*AW-1:0]     wr_addr,
    input  logic [NWR*XLEN-1:0]   wr_data,
    input  logic                  issue_en,
    input  logic [AW-1:0]         issue_addr,
    input  logic                  flush,
    output logic [AW:0]           busy_count
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [NREGS-1:0] wr_hit;

    logic [AW-1:0]    ra    [NRD];
    logic [XLEN-1:0]  rdata [NRD];
    logic [NRD-1:0]   rbusy;
    logic [AW-1:0]    wa    [NWR];
    logic [XLEN-1:0]  wd    [NWR];

    function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int k = 0; k < NREGS; k++) begin
            c = c + (AW+1)'(v[k]);
        end
        return c;
    endfunction

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        assign ra[i] = rd_addr[i*AW +: AW];
        assign rd_data[i*XLEN +: XLEN] = rdata[i];
    end
    assign rd_busy = rbusy;

    for (genvar j = 0; j < NWR; j++) begin : g_wr
        assign wa[j] = wr_addr[j*AW +: AW];
        assign wd[j] = wr_data[j*XLEN +: XLEN];
    end

    // Ascending port order makes the highest-index port the last assignment, so it wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wa[j] != '0)) begin
                    regs[wa[j]] <= wd[j];
                end
            end
        end
    end

    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < NREGS; r++) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wa[j] == r[AW-1:0])) begin
                    wr_hit[r] = 1'b1;
                end
            end
        end
    end

    // Issue is applied after the writeback clear so a newer producer keeps ownership.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            busy_nxt = busy & ~wr_hit;
            if (issue_en) begin
                busy_nxt[issue_addr] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_count <= popcount(busy_nxt);
        end
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rdata[i] = regs[ra[i]];
            rbusy[i] = busy[ra[i]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en[j] && (wa[j] == ra[i])) begin
                        rdata[i] = wd[j];
                        rbusy[i] = 1'b0;
                    end
                end
            end
            if (reset || (ra[i] == '0)) begin
                rdata[i] = '0;
                rbusy[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: hand-computed vector table, reset corner sequence and
// randomized traffic against an array-based model, on BYPASS=1 and BYPASS=0 instances.
module tb_regfile_mp;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data_b1, rd_data_b0;
    logic [NRD-1:0]      rd_busy_b1, rd_busy_b0;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                issue_en;
    logic [AW-1:0]       issue_addr;
    logic                flush;
    logic [AW:0]         busy_count_b1, busy_count_b0;

    int total = 0;
    int bad   = 0;

    logic [XLEN-1:0] mregs [NREGS];
    bit              mbusy [NREGS];

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_b1 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b1), .rd_busy(rd_busy_b1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
        .issue_addr(issue_addr), .flush(flush), .busy_count(busy_count_b1));

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_b0 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b0), .rd_busy(rd_busy_b0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
        .issue_addr(issue_addr), .flush(flush), .busy_count(busy_count_b0));

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        ie;
        logic [4:0]  ia;
        logic        fl;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic        e_bz0;
        logic        e_bz1;
        int          e_cnt;
    } vec_t;

    localparam int NT = 15;
    vec_t tbl [NT];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            mregs[r] = '0;
            mbusy[r] = 1'b0;
        end
    endtask

    task automatic model_read(input logic [AW-1:0] a, input bit byp,
                              output logic [XLEN-1:0] d, output logic b);
        bit found;
        found = 1'b0;
        d = mregs[a];
        b = mbusy[a];
        if (byp) begin
            for (int j = NWR - 1; j >= 0; j--) begin
                if (!found && wr_en[j] && wr_addr[j*AW +: AW] == a) begin
                    d = wr_data[j*XLEN +: XLEN];
                    b = 1'b0;
                    found = 1'b1;
                end
            end
        end
        if (reset || a == 0) begin
            d = '0;
            b = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [XLEN-1:0] nregs [NREGS];
        bit written [NREGS];
        nregs = mregs;
        for (int r = 0; r < NREGS; r++) written[r] = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] != 0) begin
                nregs[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
                written[wr_addr[j*AW +: AW]] = 1'b1;
            end
        end
        if (flush) begin
            for (int r = 0; r < NREGS; r++) mbusy[r] = 1'b0;
        end else begin
            for (int r = 1; r < NREGS; r++) if (written[r]) mbusy[r] = 1'b0;
            if (issue_en && issue_addr != 0) mbusy[issue_addr] = 1'b1;
        end
        mregs = nregs;
    endtask

    function automatic int model_count();
        int c = 0;
        for (int r = 0; r < NREGS; r++) c += int'(mbusy[r]);
        return c;
    endfunction

    task automatic check_all(input string tag);
        logic [XLEN-1:0] d;
        logic b;
        for (int p = 0; p < NRD; p++) begin
            model_read(rd_addr[p*AW +: AW], 1'b1, d, b);
            chk($sformatf("%s.b1.rd%0d", tag, p), 64'(rd_data_b1[p*XLEN +: XLEN]), 64'(d));
            chk($sformatf("%s.b1.bz%0d", tag, p), 64'(rd_busy_b1[p]), 64'(b));
            model_read(rd_addr[p*AW +: AW], 1'b0, d, b);
            chk($sformatf("%s.b0.rd%0d", tag, p), 64'(rd_data_b0[p*XLEN +: XLEN]), 64'(d));
            chk($sformatf("%s.b0.bz%0d", tag, p), 64'(rd_busy_b0[p]), 64'(b));
        end
        chk({tag, ".b1.cnt"}, 64'(busy_count_b1), 64'(model_count()));
        chk({tag, ".b0.cnt"}, 64'(busy_count_b0), 64'(model_count()));
    endtask

    task automatic apply(input vec_t v);
        wr_en      = v.we;
        wr_addr    = {v.wa1, v.wa0};
        wr_data    = {v.wd1, v.wd0};
        rd_addr    = {v.ra1, v.ra0};
        issue_en   = v.ie;
        issue_addr = v.ia;
        flush      = v.fl;
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
    endtask

    initial begin
        //           we     wa0    wd0           wa1    wd1           ra0    ra1    ie    ia     fl    e_rd0         e_rd1         bz0   bz1   cnt
        tbl[0]  = '{2'b01, 5'd7,  32'h12345678, 5'd0,  32'h0,        5'd7,  5'd7,  1'b0, 5'd0,  1'b0, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 0};
        tbl[1]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd7,  5'd0,  1'b0, 5'd0,  1'b0, 32'h12345678, 32'h0,        1'b0, 1'b0, 0};
        tbl[2]  = '{2'b11, 5'd9,  32'hAAAA0000, 5'd9,  32'h5555FFFF, 5'd9,  5'd7,  1'b0, 5'd0,  1'b0, 32'h5555FFFF, 32'h12345678, 1'b0, 1'b0, 0};
        tbl[3]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd9,  5'd0,  1'b0, 5'd0,  1'b0, 32'h5555FFFF, 32'h0,        1'b0, 1'b0, 0};
        tbl[4]  = '{2'b01, 5'd0,  32'hFFFFFFFF, 5'd0,  32'h0,        5'd0,  5'd0,  1'b1, 5'd0,  1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 0};
        tbl[5]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd3,  5'd0,  1'b1, 5'd3,  1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1};
        tbl[6]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd3,  5'd4,  1'b1, 5'd4,  1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 2};
        tbl[7]  = '{2'b01, 5'd3,  32'h33,       5'd0,  32'h0,        5'd3,  5'd4,  1'b0, 5'd0,  1'b0, 32'h33,       32'h0,        1'b0, 1'b1, 1};
        tbl[8]  = '{2'b01, 5'd4,  32'h44,       5'd0,  32'h0,        5'd4,  5'd3,  1'b1, 5'd4,  1'b0, 32'h44,       32'h33,       1'b0, 1'b0, 1};
        tbl[9]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd4,  5'd3,  1'b0, 5'd0,  1'b0, 32'h44,       32'h33,       1'b1, 1'b0, 1};
        tbl[10] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd1,  5'd2,  1'b1, 5'd1,  1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 2};
        tbl[11] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd1,  5'd2,  1'b1, 5'd2,  1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 3};
        tbl[12] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd2,  5'd3,  1'b1, 5'd3,  1'b0, 32'h0,        32'h33,       1'b1, 1'b0, 4};
        tbl[13] = '{2'b01, 5'd2,  32'h77,       5'd0,  32'h0,        5'd2,  5'd6,  1'b1, 5'd6,  1'b1, 32'h77,       32'h0,        1'b0, 1'b0, 0};
        tbl[14] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd2,  5'd6,  1'b0, 5'd0,  1'b0, 32'h77,       32'h0,        1'b0, 1'b0, 0};

        // Power-on reset
        reset = 1'b1;
        idle();
        model_reset();
        @(posedge clk); #1;
        check_all("rst");
        #2 reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NT; i++) begin
            apply(tbl[i]);
            #2;
            chk($sformatf("vec%0d.rd0", i), 64'(rd_data_b1[31:0]),  64'(tbl[i].e_rd0));
            chk($sformatf("vec%0d.rd1", i), 64'(rd_data_b1[63:32]), 64'(tbl[i].e_rd1));
            chk($sformatf("vec%0d.bz0", i), 64'(rd_busy_b1[0]),     64'(tbl[i].e_bz0));
            chk($sformatf("vec%0d.bz1", i), 64'(rd_busy_b1[1]),     64'(tbl[i].e_bz1));
            check_all($sformatf("vec%0d.pre", i));
            @(posedge clk);
            model_edge();
            #1;
            chk($sformatf("vec%0d.cnt", i), 64'(busy_count_b1), 64'(tbl[i].e_cnt));
        end

        // Without bypass a same-cycle write is invisible until after the edge
        idle();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd12}; wr_data = {32'h0, 32'hCAFE0012};
        rd_addr = {5'd0, 5'd12};
        #2;
        chk("nobyp.before", 64'(rd_data_b0[31:0]), 64'h0);
        chk("byp.before",   64'(rd_data_b1[31:0]), 64'hCAFE0012);
        @(posedge clk); model_edge(); #1;
        wr_en = '0;
        #1;
        chk("nobyp.after",  64'(rd_data_b0[31:0]), 64'hCAFE0012);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            wr_en      = NWR'($urandom_range(0, 3));
            wr_addr    = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
            wr_data    = {$urandom, $urandom};
            issue_en   = 1'($urandom_range(0, 1));
            issue_addr = 5'($urandom_range(0, 15));
            flush      = ($urandom_range(0, 15) == 0);
            rd_addr[4:0] = ($urandom_range(0, 1) != 0) ? wr_addr[4:0] : 5'($urandom_range(0, 31));
            rd_addr[9:5] = ($urandom_range(0, 1) != 0) ? wr_addr[9:5] : 5'($urandom_range(0, 15));
            #2;
            check_all($sformatf("rnd%0d", n));
            @(posedge clk);
            model_edge();
            #1;
            chk($sformatf("rnd%0d.cnt", n), 64'(busy_count_b1), 64'(model_count()));
        end

        // Reset asserted mid-cycle while a write and issue are in flight
        @(posedge clk); #1;
        idle();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
        issue_en = 1'b1; issue_addr = 5'd5;
        @(posedge clk); model_edge(); #1;
        wr_data = {32'h0, 32'h0BADF00D};
        issue_en = 1'b0;
        rd_addr = {5'd0, 5'd5};
        #1;
        chk("prerst.b0.x5", 64'(rd_data_b0[31:0]), 64'hDEADBEEF);
        chk("prerst.b0.bz", 64'(rd_busy_b0[0]),    64'h1);
        reset = 1'b1;
        model_reset();
        #1;
        chk("midrst.b1.x5", 64'(rd_data_b1[31:0]), 64'h0);
        chk("midrst.b0.x5", 64'(rd_data_b0[31:0]), 64'h0);
        chk("midrst.cnt",   64'(busy_count_b1),    64'h0);
        check_all("midrst");
        @(posedge clk); #1;
        check_all("inrst");
        #2 reset = 1'b0;
        wr_en = '0;
        #1;
        chk("postrst.b0.x5", 64'(rd_data_b0[31:0]), 64'h0);
        check_all("postrst");
        wr_en = 2'b10; wr_addr = {5'd5, 5'd0}; wr_data = {32'h00C0FFEE, 32'h0};
        @(posedge clk); model_edge(); #1;
        wr_en = '0;
        #1;
        chk("resume.b0.x5", 64'(rd_data_b0[31:0]), 64'h00C0FFEE);
        check_all("resume");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a per-register busy scoreboard, for the pipelined core that follows the single-cycle datapath. It provides NRD combinational read ports and NWR synchronous write ports, with optional same-cycle write-to-read bypass. A busy bit per register is set when an instruction issues and cleared on writeback, so the hazard unit can stall on RAW dependencies. All state is cleared by an asynchronous reset.

## Interface
- XLEN, 32: data width in bits.
- NREGS, 32: number of registers; power of two, ≥ 2. AW = $clog2(NREGS).
- NRD, 2: number of read ports, ≥ 1.
- NWR, 2: number of write ports, ≥ 1.
- BYPASS, 1: 1 = a same-cycle write is forwarded to matching reads; 0 = reads return stored contents only.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- rd_addr  in  NRD*AW  read addresses; port i is bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data; port i is bits [i*XLEN +: XLEN].
- rd_busy  out  NRD  1 = the register read on port i has a pending writeback.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  write addresses, packed like rd_addr.
- wr_data  in  NWR*XLEN  write data, packed like rd_data.
- issue_en  in  1  marks issue_addr busy (pending producer).
- issue_addr  in  AW  destination register of the issuing instruction.
- flush  in  1  clears every busy bit (pipeline flush).
- busy_count  out  AW+1  number of busy bits currently set (registered).

## Operation
- Storage: regs[NREGS] of XLEN bits, plus busy[NREGS].
- Register 0 reads as 0 and is never busy. Writes and issues to address 0 are ignored.
- Write: at the clock edge, for each j with wr_en[j]=1 and wr_addr[j]≠0, set regs[wr_addr[j]] = wr_data[j].
- Write conflict: if several enabled ports share an address, the highest-index port wins.
- Read (combinational), port i, address a:
  - a = 0: rd_data = 0.
  - BYPASS=1 and some enabled write port j has wr_addr[j] = a: rd_data = wr_data of the highest such j.
  - Otherwise: rd_data = regs[a].
- rd_busy[i]:
  - a = 0: 0.
  - BYPASS=1 and a matching enabled write is present: 0.
  - Otherwise: busy[a]. Same-cycle issue_en does not affect rd_busy.
- Busy update at the clock edge, in priority order:
  1. flush=1: all busy bits ← 0. A same-cycle issue is dropped; same-cycle writes still update regs.
  2. Otherwise, issue_en=1 with issue_addr≠0: busy[issue_addr] ← 1. This wins over a same-cycle write to the same address, because the newer producer takes ownership.
  3. Any enabled write to a nonzero address that is not the issue target: busy ← 0.
- busy_count: registered population count of the next-state busy vector. It always equals the number of set bits in busy.

## Timing
- Read latency: 0 cycles (combinational from rd_addr, wr_*, and state).
- Write latency: stored data is visible with BYPASS=0 in the cycle after the edge; with BYPASS=1 it is also visible in the write cycle itself.
- Issue → rd_busy=1 in the cycle after the edge.
- Writeback → rd_busy=0 in the same cycle when BYPASS=1, otherwise the cycle after.
- Reset (asynchronous, any time, including mid-write or mid-issue):
  - all regs = 0, all busy = 0, busy_count = 0;
  - rd_data = 0 and rd_busy = 0 for every address.
  - Inputs are ignored while reset=1. The first update occurs on the first edge after deassertion.
- busy_count never exceeds NREGS-1, because register 0 is excluded.

## Test plan
- Reset: write 0xDEADBEEF to x5, assert reset mid-cycle → rd_data for x5 = 0 immediately, busy_count = 0.
- Bypass (BYPASS=1): wr_en[0]=1, wr_addr=7, wr_data=0x12345678, rd_addr[1]=7 in the same cycle → rd_data[1]=0x12345678 before the edge. With BYPASS=0 it reads 0 until the next cycle.
- Write conflict: ports 0 and 1 both write x9 with 0xAAAA0000 and 0x5555FFFF → x9 = 0x5555FFFF afterwards.
- x0 protection: write 0xFFFFFFFF to x0 and issue x0 → rd_data = 0, rd_busy = 0, busy_count unchanged.
- Scoreboard:
  - Issue x3, then x4 → busy_count = 2, rd_busy for x3 = 1.
  - Write x3 → busy_count = 1.
  - Issue x4 and write x4 in the same cycle → x4 stays busy, busy_count = 1.
- Flush: busy on x1, x2 and x3, then flush with issue x6 and a write of 0x77 to x2 in the same cycle → busy_count = 0, x6 not busy, x2 = 0x77.
